// File: rtl/cr_cddip_int_coalesce_if.sv
// Interrupt-coalescer signal bundle: CDDIP-side inputs, config, host side.
// The slave modport is the coalescer's view of the bundle.
interface cr_cddip_int_coalesce_if #(
    parameter int CNT_W = 8,
    parameter int TMR_W = 16
);
    logic             cddip_int;
    logic             cddip_idle;
    logic             cfg_enable;
    logic [CNT_W-1:0] cfg_cnt_thresh;
    logic [TMR_W-1:0] cfg_tmr_thresh;
    logic             host_int_ack;
    logic             host_int;
    logic [CNT_W-1:0] pend_cnt;
    logic             evt_ovf;
    logic [1:0]       coal_state;

    modport master (
        output cddip_int, cddip_idle, cfg_enable,
        output cfg_cnt_thresh, cfg_tmr_thresh, host_int_ack,
        input  host_int, pend_cnt, evt_ovf, coal_state
    );

    modport slave (
        input  cddip_int, cddip_idle, cfg_enable,
        input  cfg_cnt_thresh, cfg_tmr_thresh, host_int_ack,
        output host_int, pend_cnt, evt_ovf, coal_state
    );
endinterface

// File: rtl/cr_cddip_int_coalesce.sv
// Interrupt coalescer: batches CDDIP events by count/timer into one host interrupt.
// Optional CR_CDDIP_INT_COALESCE_IDLE_FLUSH_EN: engine idle flushes pending events.
module cr_cddip_int_coalesce #(
    parameter int CNT_W = 8,
    parameter int TMR_W = 16
) (
    input logic clk,
    input logic rst,
    cr_cddip_int_coalesce_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        FIRE    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] pend, pend_n;
    logic [CNT_W-1:0] shadow, shadow_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             ovf, ovf_n;
    logic             host, host_n;
    logic             int_q;

    logic             evt;
    logic             flush;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] pend_inc;
    logic [CNT_W-1:0] shadow_inc;
    logic [CNT_W-1:0] sh_post;
    logic [TMR_W-1:0] timer_inc;

    assign evt        = bus.cddip_int & ~int_q;
    assign thr        = (bus.cfg_cnt_thresh == '0) ? CNT_ONE : bus.cfg_cnt_thresh;
    assign pend_inc   = (pend == CNT_MAX) ? pend : pend + CNT_ONE;
    assign shadow_inc = (shadow == CNT_MAX) ? shadow : shadow + CNT_ONE;
    assign timer_inc  = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
    assign sh_post    = evt ? shadow_inc : shadow;

`ifdef CR_CDDIP_INT_COALESCE_IDLE_FLUSH_EN
    assign flush = bus.cddip_idle & (pend != '0);
`else
    logic unused_idle;
    assign unused_idle = bus.cddip_idle;
    assign flush = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        pend_n   = pend;
        shadow_n = shadow;
        timer_n  = timer;
        ovf_n    = ovf;
        if (!bus.cfg_enable) begin
            state_n  = IDLE;
            pend_n   = '0;
            shadow_n = '0;
            timer_n  = '0;
            ovf_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (evt) begin
                        pend_n   = CNT_ONE;
                        timer_n  = '0;
                        shadow_n = '0;
                        state_n  = (thr == CNT_ONE) ? FIRE : COLLECT;
                    end
                end
                COLLECT: begin
                    timer_n = timer_inc;
                    if (evt) begin
                        pend_n = pend_inc;
                        if (pend == CNT_MAX) ovf_n = 1'b1;
                    end
                    if ((pend_n >= thr) || flush ||
                        ((bus.cfg_tmr_thresh != '0) &&
                         (timer_n >= bus.cfg_tmr_thresh))) begin
                        state_n  = FIRE;
                        shadow_n = '0;
                    end
                end
                FIRE: begin
                    shadow_n = sh_post;
                    if (evt && (shadow == CNT_MAX)) ovf_n = 1'b1;
                    // Ack hands any events that arrived during FIRE to a fresh batch
                    if (bus.host_int_ack) begin
                        ovf_n    = 1'b0;
                        timer_n  = '0;
                        shadow_n = '0;
                        if (sh_post != '0) begin
                            state_n = COLLECT;
                            pend_n  = sh_post;
                        end else begin
                            state_n = IDLE;
                            pend_n  = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        host_n = bus.cfg_enable ? (state_n == FIRE) : bus.cddip_int;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            shadow <= '0;
            timer  <= '0;
            ovf    <= 1'b0;
            host   <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            shadow <= shadow_n;
            timer  <= timer_n;
            ovf    <= ovf_n;
            host   <= host_n;
            int_q  <= bus.cddip_int;
        end
    end

    assign bus.host_int   = host;
    assign bus.pend_cnt   = pend;
    assign bus.evt_ovf    = ovf;
    assign bus.coal_state = state;
endmodule

// File: tb/tb_cr_cddip_int_coalesce.sv
// Directed plus randomized bench for the interrupt coalescer against a
// behavioural model of its batching rules.
module tb_cr_cddip_int_coalesce;
    localparam int CMAX = 255;
    localparam int TMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    cr_cddip_int_coalesce_if #(.CNT_W(8), .TMR_W(16)) bus ();

    cr_cddip_int_coalesce #(.CNT_W(8), .TMR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model: phase 0 idle, 1 collecting, 2 firing
    int m_phase, m_pend, m_sh, m_tmr, m_ovf, m_host, m_prev;

    task automatic model_step();
        bit ev;
        int eth;
        bit hit;
        ev  = bus.cddip_int && !m_prev;
        eth = (bus.cfg_cnt_thresh == 0) ? 1 : int'(bus.cfg_cnt_thresh);
        if (rst) begin
            m_phase = 0; m_pend = 0; m_sh = 0; m_tmr = 0;
            m_ovf = 0; m_host = 0; m_prev = 0;
            return;
        end
        m_prev = bus.cddip_int;
        if (!bus.cfg_enable) begin
            m_phase = 0; m_pend = 0; m_sh = 0; m_tmr = 0; m_ovf = 0;
            m_host = bus.cddip_int;
            return;
        end
        if (m_phase == 0) begin
            if (ev) begin
                m_pend = 1; m_tmr = 0; m_sh = 0;
                m_phase = (eth == 1) ? 2 : 1;
            end
        end else if (m_phase == 1) begin
            hit = 0;
`ifdef CR_CDDIP_INT_COALESCE_IDLE_FLUSH_EN
            if (bus.cddip_idle && m_pend > 0) hit = 1;
`endif
            m_tmr = (m_tmr + 1 > TMAX) ? TMAX : m_tmr + 1;
            if (ev) begin
                if (m_pend == CMAX) m_ovf = 1;
                else m_pend++;
            end
            if (m_pend >= eth) hit = 1;
            if (bus.cfg_tmr_thresh != 0 && m_tmr >= int'(bus.cfg_tmr_thresh)) hit = 1;
            if (hit) begin
                m_phase = 2; m_sh = 0;
            end
        end else begin
            if (ev) begin
                if (m_sh == CMAX) m_ovf = 1;
                else m_sh++;
            end
            if (bus.host_int_ack) begin
                m_ovf = 0; m_tmr = 0;
                if (m_sh > 0) begin
                    m_phase = 1; m_pend = m_sh;
                end else begin
                    m_phase = 0; m_pend = 0;
                end
                m_sh = 0;
            end
        end
        m_host = (m_phase == 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("host_int", 32'(bus.host_int), 32'(m_host));
        chk("pend_cnt", 32'(bus.pend_cnt), 32'(m_pend));
        chk("evt_ovf", 32'(bus.evt_ovf), 32'(m_ovf));
        chk("coal_state", 32'(bus.coal_state), 32'(m_phase));
    endtask

    task automatic pulse();
        bus.cddip_int = 1'b1;
        tick();
        bus.cddip_int = 1'b0;
        tick();
    endtask

    task automatic ack();
        bus.host_int_ack = 1'b1;
        tick();
        bus.host_int_ack = 1'b0;
    endtask

    initial begin
        int n;
        bus.cddip_int      = 1'b0;
        bus.cddip_idle     = 1'b0;
        bus.cfg_enable     = 1'b1;
        bus.cfg_cnt_thresh = 8'd4;
        bus.cfg_tmr_thresh = 16'd0;
        bus.host_int_ack   = 1'b0;

        // reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(bus.coal_state), 32'd0);
        chk("rst_host", 32'(bus.host_int), 32'd0);
        rst = 1'b0;

        // count threshold 4, pulses spaced 3 cycles
        for (int i = 0; i < 4; i++) begin
            bus.cddip_int = 1'b1;
            tick();
            bus.cddip_int = 1'b0;
            if (i < 3) begin
                chk("cnt4_not_yet", 32'(bus.host_int), 32'd0);
                tick();
                tick();
            end
        end
        chk("cnt4_fire", 32'(bus.host_int), 32'd1);
        chk("cnt4_pend", 32'(bus.pend_cnt), 32'd4);
        ack();
        chk("cnt4_ack_idle", 32'(bus.coal_state), 32'd0);

        // timer fire, 20 edges after entry
        bus.cfg_cnt_thresh = 8'd8;
        bus.cfg_tmr_thresh = 16'd20;
        bus.cddip_int = 1'b1;
        tick();
        bus.cddip_int = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.host_int) begin
                n = i;
                break;
            end
        end
        chk("tmr_latency", 32'(n), 32'd20);
        chk("tmr_pend", 32'(bus.pend_cnt), 32'd1);

        // two events during FIRE then ack
        bus.cddip_int = 1'b1;
        tick();
        bus.cddip_int = 1'b0;
        tick();
        bus.cddip_int = 1'b1;
        tick();
        bus.cddip_int = 1'b0;
        ack();
        chk("ack_collect", 32'(bus.coal_state), 32'd1);
        chk("ack_pend2", 32'(bus.pend_cnt), 32'd2);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.host_int) begin
                n = i;
                break;
            end
        end
        chk("restart_tmr", 32'(n), 32'd20);
        ack();
        chk("ack_alone_idle", 32'(bus.coal_state), 32'd0);
        chk("ack_alone_pend", 32'(bus.pend_cnt), 32'd0);

        // ack outside FIRE ignored
        ack();
        chk("ack_ignored", 32'(bus.coal_state), 32'd0);

        // saturation at 255
        bus.cfg_cnt_thresh = 8'hFF;
        bus.cfg_tmr_thresh = 16'd0;
        for (int i = 0; i < 255; i++) pulse();
        chk("sat_fire", 32'(bus.coal_state), 32'd2);
        chk("sat_pend", 32'(bus.pend_cnt), 32'd255);
        for (int i = 0; i < 345; i++) pulse();
        chk("sat_ovf", 32'(bus.evt_ovf), 32'd1);
        chk("sat_hold", 32'(bus.pend_cnt), 32'd255);
        ack();
        chk("sat_ovf_clr", 32'(bus.evt_ovf), 32'd0);
        chk("sat_carry", 32'(bus.pend_cnt), 32'd255);
        tick();
        chk("sat_refire", 32'(bus.host_int), 32'd1);
        ack();

        // live threshold lowering
        bus.cfg_cnt_thresh = 8'd8;
        for (int i = 0; i < 3; i++) pulse();
        chk("live_wait", 32'(bus.host_int), 32'd0);
        bus.cfg_cnt_thresh = 8'd2;
        tick();
        chk("live_fire", 32'(bus.host_int), 32'd1);
        ack();

        // threshold 0 acts as 1
        bus.cfg_cnt_thresh = 8'd0;
        bus.cddip_int = 1'b1;
        tick();
        chk("thr0_fire", 32'(bus.host_int), 32'd1);
        bus.cddip_int = 1'b0;
        ack();

        // idle flush
        bus.cfg_cnt_thresh = 8'd8;
        pulse();
        pulse();
        bus.cddip_idle = 1'b1;
        tick();
`ifdef CR_CDDIP_INT_COALESCE_IDLE_FLUSH_EN
        chk("idle_flush", 32'(bus.host_int), 32'd1);
`else
        chk("idle_noflush", 32'(bus.host_int), 32'd0);
`endif
        bus.cddip_idle = 1'b0;

        // bypass mirrors input one cycle late
        bus.cfg_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.cddip_int = 1'((8'b10110010 >> i) & 1);
            tick();
            chk("bypass_host", 32'(bus.host_int), 32'(bus.cddip_int));
            chk("bypass_pend", 32'(bus.pend_cnt), 32'd0);
        end
        bus.cddip_int = 1'b0;
        tick();
        bus.cfg_enable = 1'b1;

        // reset in FIRE
        bus.cfg_cnt_thresh = 8'd1;
        pulse();
        chk("pre_rst_fire", 32'(bus.coal_state), 32'd2);
        rst = 1'b1;
        tick();
        chk("rst_fire_host", 32'(bus.host_int), 32'd0);
        chk("rst_fire_state", 32'(bus.coal_state), 32'd0);
        rst = 1'b0;

        // randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            bus.cfg_cnt_thresh = 8'($urandom_range(0, 6));
            bus.cfg_tmr_thresh = 16'($urandom_range(0, 12));
            for (int i = 0; i < 200; i++) begin
                bus.cddip_int    = ($urandom_range(0, 2) == 0);
                bus.host_int_ack = ($urandom_range(0, 3) == 0);
                bus.cddip_idle   = ($urandom_range(0, 5) == 0);
                bus.cfg_enable   = ($urandom_range(0, 49) != 0);
                rst              = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 1'b0;
        bus.host_int_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
